// File: rtl/jk_cmd_driver.sv
// Queued J/K command sequencer: buffers {op,len} commands and replays each op for len+1 cycles.
// Optional Q reference checker is enabled with the JK_CMD_CHECK_EN macro.
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             q_in,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_mem  [DEPTH];
    logic [CNT_W-1:0] len_mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0] remaining;
    logic             full, empty, push, pop, jk_clr;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    assign head_op   = op_mem[rd_ptr[AW-1:0]];
    assign head_len  = len_mem[rd_ptr[AW-1:0]];
    assign busy      = (state == RUN) | ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!empty) state_nxt = RUN;
            RUN:  if (remaining == '0 && empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        jk_clr = 1'b0;
        case (state)
            IDLE: pop = ~empty;
            RUN: begin
                if (remaining == '0) begin
                    if (!empty) pop    = 1'b1;
                    else        jk_clr = 1'b1;
                end
            end
            default: jk_clr = 1'b1;
        endcase
    end

    // FIFO storage carries no reset; only pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr[AW-1:0]]  <= cmd_op;
            len_mem[wr_ptr[AW-1:0]] <= cmd_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                {j, k}    <= head_op;
                remaining <= head_len;
            end else if (state == RUN && remaining != '0) begin
                remaining <= remaining - CNT_ONE;
            end else if (jk_clr) begin
                {j, k} <= 2'b00;
            end
        end
    end

`ifdef JK_CMD_CHECK_EN
    logic qm, qm_valid;

    // qm tracks what the flip-flop should hold after the J/K pair now on the outputs is applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qm       <= 1'b0;
            qm_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   qm <= 1'b0;
                2'b10:   qm <= 1'b1;
                2'b11:   qm <= ~qm;
                default: qm <= qm;
            endcase
            if (j ^ k) qm_valid <= 1'b1;
            if (qm_valid && (q_in != qm)) err <= 1'b1;
        end
    end
`else
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Self-checking bench for jk_cmd_driver: directed table, multi-cycle corner sequences,
// and randomized traffic against an op-stream reference model.
module tb_jk_cmd_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_len = 4'd0;
    logic       q_in;
    logic       j, k, busy, err;

    logic       q_ff = 1'b0;
    logic       q_force0 = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    jk_cmd_driver #(.DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .q_in(q_in),
        .j(j), .k(k), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural JK flip-flop fed by the DUT, providing correct Q feedback.
    always @(posedge clk) begin
        case ({j, k})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end
    assign q_in = q_force0 ? 1'b0 : q_ff;

    typedef struct {
        logic       vld;
        logic [1:0] op;
        logic [3:0] len;
        logic [1:0] exp_jk;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic [1:0] op;
        bit         first;
    } elem_t;

    vec_t  tbl[10];
    elem_t sched[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] len);
        cmd_valid = v;
        cmd_op    = op;
        cmd_len   = len;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 2'b00, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    function automatic int pending_cmds();
        int c;
        c = 0;
        foreach (sched[i]) if (sched[i].first) c++;
        return c;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_jk;
        logic       exp_busy;
        logic       m_ready;
        int         acc;

        // T1: asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("t1_jk",    {30'd0, j, k},     32'd0);
        check("t1_busy",  {31'd0, busy},      32'd0);
        check("t1_err",   {31'd0, err},       32'd0);
        check("t1_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // T2 single command, then T3 back-to-back commands
        tbl[0] = '{1'b1, 2'b10, 4'd2, 2'b00, 1'b1};
        tbl[1] = '{1'b0, 2'b00, 4'd0, 2'b10, 1'b1};
        tbl[2] = '{1'b0, 2'b00, 4'd0, 2'b10, 1'b1};
        tbl[3] = '{1'b0, 2'b00, 4'd0, 2'b10, 1'b1};
        tbl[4] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b0};
        tbl[5] = '{1'b1, 2'b10, 4'd0, 2'b00, 1'b1};
        tbl[6] = '{1'b1, 2'b11, 4'd1, 2'b10, 1'b1};
        tbl[7] = '{1'b0, 2'b00, 4'd0, 2'b11, 1'b1};
        tbl[8] = '{1'b0, 2'b00, 4'd0, 2'b11, 1'b1};
        tbl[9] = '{1'b0, 2'b00, 4'd0, 2'b00, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].vld, tbl[i].op, tbl[i].len);
            @(negedge clk);
            check($sformatf("tbl%0d_jk", i),   {30'd0, j, k},  {30'd0, tbl[i].exp_jk});
            check($sformatf("tbl%0d_busy", i), {31'd0, busy},  {31'd0, tbl[i].exp_busy});
        end
        drive(1'b0, 2'b00, 4'd0);

        // T4: long command then continuous pushes until the FIFO fills
        drive(1'b1, 2'b10, 4'd15);
        acc = 0;
        for (int e = 0; e <= 17; e++) begin
            if (cmd_valid && cmd_ready) acc++;
            @(negedge clk);
            if (e == 0)  drive(1'b1, 2'b11, 4'd0);
            if (e == 4)  check("t4_full_ready",  {31'd0, cmd_ready}, 32'd0);
            if (e == 16) begin
                check("t4_ready_pre_pop", {31'd0, cmd_ready}, 32'd0);
                check("t4_jk_first",      {30'd0, j, k},      32'd2);
            end
            if (e == 17) begin
                check("t4_ready_post_pop", {31'd0, cmd_ready}, 32'd1);
                check("t4_jk_second",      {30'd0, j, k},      32'd3);
                drive(1'b0, 2'b00, 4'd0);
            end
        end
        check("t4_accepted", acc, 32'd5);
        wait_idle(50);

        // T5: reset while a toggle is running with commands queued
        drive(1'b1, 2'b11, 4'd15);
        @(negedge clk);
        drive(1'b1, 2'b10, 4'd3);
        repeat (3) @(negedge clk);
        drive(1'b0, 2'b00, 4'd0);
        @(negedge clk);
        check("t5_running_jk", {30'd0, j, k}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("t5_async_jk",   {30'd0, j, k},     32'd0);
        check("t5_async_busy", {31'd0, busy},      32'd0);
        check("t5_async_rdy",  {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t5_no_replay", {29'd0, busy, j, k}, 32'd0);
        end

`ifdef JK_CMD_CHECK_EN
        // T6: Q checker with wrong and correct feedback
        q_force0 = 1'b1;
        do_reset();
        drive(1'b1, 2'b10, 4'd0);
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 4'd0);
            if (e == 2) check("t6_err_before", {31'd0, err}, 32'd0);
            if (e == 3) check("t6_err_set",    {31'd0, err}, 32'd1);
            if (e == 6) check("t6_err_sticky", {31'd0, err}, 32'd1);
        end
        q_force0 = 1'b0;
        do_reset();
        drive(1'b1, 2'b10, 4'd0);
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 4'd0);
        end
        check("t6_err_clean", {31'd0, err}, 32'd0);
`endif

        // Randomized traffic against the op-stream model
        do_reset();
        sched.delete();
        exp_jk   = 2'b00;
        exp_busy = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic       v, active;
            logic [1:0] op;
            logic [3:0] len;
            elem_t      e;
            m_ready = (pending_cmds() < 4);
            check("rnd_jk",    {30'd0, j, k},     {30'd0, exp_jk});
            check("rnd_busy",  {31'd0, busy},      {31'd0, exp_busy});
            check("rnd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
            check("rnd_err",   {31'd0, err},       32'd0);
            v   = ($urandom_range(0, 9) < 6);
            op  = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            drive(v, op, len);
            active = (sched.size() > 0);
            if (active) begin
                e      = sched.pop_front();
                exp_jk = e.op;
            end else begin
                exp_jk = 2'b00;
            end
            if (v && m_ready)
                for (int i = 0; i <= int'(len); i++) sched.push_back('{op, (i == 0)});
            exp_busy = active || (sched.size() > 0);
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 4'd0);
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
